// File: rtl/paicore_recv_pkg.sv
// Shared types and default widths for the PAICORE receive run controller.
package paicore_recv_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_IDLE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RECV  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/recv_idle_timer.sv
// Idle-cycle counter: counts while enabled and not cleared, flags the cycle it reaches limit-1.
module recv_idle_timer #(
  parameter int IDLE_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [IDLE_W-1:0] i_limit,
  output logic              o_expire
);

  logic [IDLE_W-1:0] r_cnt;

  // Saturates so a disabled (limit 0) run never wraps back through small values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + IDLE_W'(1);
    end
  end

  assign o_expire = i_en && !i_clr && (i_limit != '0) &&
                    (r_cnt == (i_limit - IDLE_W'(1)));

endmodule

// File: rtl/paicore_recv_ctrl.sv
// Run controller for the PAICORE receive datapath: arm channels, count frames, end the run,
// flush transport_up, wait for the fifo to drain and report completion.
module paicore_recv_ctrl
  import paicore_recv_pkg::*;
#(
  parameter int CHANNEL = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int IDLE_W  = DEF_IDLE_W
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_aresetn,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [CHANNEL-1:0] i_ch_mask,
  input  logic [CNT_W-1:0]   i_frame_num_max,
  input  logic [IDLE_W-1:0]  i_idle_timeout,
  input  logic               i_tx_done,
  input  logic               i_snn_out_hsked,
  input  logic               i_recv_busy,
  input  logic               i_fifo_empty,
  output logic [CHANNEL-1:0] o_ien,
  output logic               o_rx_rcving,
  output logic               o_recv_done,
  output logic               o_rx_done,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_frame_cnt,
  output logic               o_timeout_flag
);

  state_e             r_state;
  state_e             w_next;
  logic [CHANNEL-1:0] r_mask;
  logic [CNT_W-1:0]   r_max;
  logic [IDLE_W-1:0]  r_timeout;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_timeout_flag;
  logic [CHANNEL-1:0] r_ien;
  logic               r_rx_rcving;
  logic               r_recv_done;
  logic               r_rx_done;
  logic               r_busy;

  logic               w_start_ok;
  logic               w_counting;
  logic [CNT_W:0]     w_cnt_sum;
  logic               w_cnt_hit;
  logic               w_tmo_hit;
  logic               w_set_tmo;
  logic               w_tmr_clr;
  logic               w_tmr_en;
  logic [CHANNEL-1:0] w_ien_nxt;
  logic               w_rcving_nxt;
  logic               w_recv_done_nxt;
  logic               w_rx_done_nxt;
  logic               w_busy_nxt;

  assign w_start_ok = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_counting = (r_state == ST_RECV) || (r_state == ST_FLUSH) || (r_state == ST_DRAIN);

  // Include this cycle's handshake so the run ends on the edge that accepts the last frame.
  assign w_cnt_sum = {1'b0, r_frame_cnt} + (CNT_W+1)'(i_snn_out_hsked);
  assign w_cnt_hit = (r_max != '0) && (w_cnt_sum >= {1'b0, r_max});

  assign w_tmr_en  = (r_state == ST_RECV);
  assign w_tmr_clr = (r_state != ST_RECV) || i_snn_out_hsked || !i_tx_done;

  recv_idle_timer #(
    .IDLE_W (IDLE_W)
  ) u_idle_timer (
    .i_clk    (m_axis_aclk),
    .i_rst_n  (m_axis_aresetn),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .i_limit  (r_timeout),
    .o_expire (w_tmo_hit)
  );

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_tmo = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_ARM;
      ST_ARM:   w_next = ST_RECV;
      ST_RECV: begin
        if (i_abort) begin
          w_next = ST_FLUSH;
        end else if (w_cnt_hit) begin
          w_next = ST_FLUSH;
        end else if (w_tmo_hit) begin
          w_next    = ST_FLUSH;
          w_set_tmo = 1'b1;
        end
      end
      ST_FLUSH: w_next = ST_DRAIN;
      ST_DRAIN: if (i_fifo_empty && !i_recv_busy) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    // Outputs are a function of the state being entered, then registered.
    w_ien_nxt       = '0;
    w_rcving_nxt    = 1'b0;
    w_recv_done_nxt = 1'b0;
    w_rx_done_nxt   = 1'b0;
    w_busy_nxt      = (w_next != ST_IDLE);
    unique case (w_next)
      ST_ARM, ST_RECV: begin
        w_ien_nxt    = w_start_ok ? i_ch_mask : r_mask;
        w_rcving_nxt = 1'b1;
      end
      ST_FLUSH: begin
        w_rcving_nxt    = 1'b1;
        w_recv_done_nxt = 1'b1;
      end
      ST_DRAIN: w_rcving_nxt  = 1'b1;
      ST_DONE:  w_rx_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_ien       <= '0;
      r_rx_rcving <= 1'b0;
      r_recv_done <= 1'b0;
      r_rx_done   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ien       <= w_ien_nxt;
      r_rx_rcving <= w_rcving_nxt;
      r_recv_done <= w_recv_done_nxt;
      r_rx_done   <= w_rx_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Run configuration is captured only when a run is accepted.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_mask    <= '0;
      r_max     <= '0;
      r_timeout <= '0;
    end else if (w_start_ok) begin
      r_mask    <= i_ch_mask;
      r_max     <= i_frame_num_max;
      r_timeout <= i_idle_timeout;
    end
  end

  // Tail frames arriving during flush/drain still count toward the run total.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_frame_cnt    <= '0;
      r_timeout_flag <= 1'b0;
    end else if (w_start_ok) begin
      r_frame_cnt    <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_counting && i_snn_out_hsked && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (w_set_tmo) begin
        r_timeout_flag <= 1'b1;
      end
    end
  end

  assign o_ien          = r_ien;
  assign o_rx_rcving    = r_rx_rcving;
  assign o_recv_done    = r_recv_done;
  assign o_rx_done      = r_rx_done;
  assign o_busy         = r_busy;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_paicore_recv_ctrl.sv
// Directed bench for paicore_recv_ctrl: frame-count, timeout, abort, reset and ignored-start runs.
module tb_paicore_recv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, tx_done, hsked, recv_busy, fifo_empty;
  logic [3:0]  mask;
  logic [31:0] fmax;
  logic [15:0] tmo;
  logic [3:0]  ien;
  logic        rx_rcving, recv_done, rx_done, busy, tmo_flag;
  logic [31:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int rxd_pulses = 0;

  always #5 clk = ~clk;

  paicore_recv_ctrl #(.CHANNEL(4), .CNT_W(32), .IDLE_W(16)) dut (
    .m_axis_aclk     (clk),
    .m_axis_aresetn  (rst_n),
    .i_start         (start),
    .i_abort         (abort),
    .i_ch_mask       (mask),
    .i_frame_num_max (fmax),
    .i_idle_timeout  (tmo),
    .i_tx_done       (tx_done),
    .i_snn_out_hsked (hsked),
    .i_recv_busy     (recv_busy),
    .i_fifo_empty    (fifo_empty),
    .o_ien           (ien),
    .o_rx_rcving     (rx_rcving),
    .o_recv_done     (recv_done),
    .o_rx_done       (rx_done),
    .o_busy          (busy),
    .o_frame_cnt     (frame_cnt),
    .o_timeout_flag  (tmo_flag)
  );

  // {ien, rx_rcving, recv_done, rx_done, busy}
  logic [7:0] ctl;
  assign ctl = {ien, rx_rcving, recv_done, rx_done, busy};

  always @(negedge clk) if (rx_done === 1'b1) rxd_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; tx_done = 0; hsked = 0;
    recv_busy = 0; fifo_empty = 1; mask = 4'h0; fmax = 0; tmo = 0;
    tick(); tick();
    chk("reset_ctl", {24'd0, ctl}, 32'h00);
    chk("reset_cnt", frame_cnt, 32'd0);
    chk("reset_tflag", {31'd0, tmo_flag}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: frame-count exit after 5 frames
    mask = 4'hF; fmax = 5; tmo = 0; start = 1;
    tick(); chk("t1_arm", {24'd0, ctl}, {24'd0, 4'hF, 4'b1001});
    start = 0;
    tick(); chk("t1_recv", {24'd0, ctl}, {24'd0, 4'hF, 4'b1001});
    hsked = 1;
    repeat (4) tick();
    chk("t1_recv4", {24'd0, ctl}, {24'd0, 4'hF, 4'b1001});
    chk("t1_cnt4", frame_cnt, 32'd4);
    tick(); chk("t1_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    chk("t1_cnt5", frame_cnt, 32'd5);
    hsked = 0; fifo_empty = 0;
    tick(); chk("t1_drain", {24'd0, ctl}, {24'd0, 4'h0, 4'b1001});
    tick(); chk("t1_drain_hold", {24'd0, ctl}, {24'd0, 4'h0, 4'b1001});
    fifo_empty = 1;
    tick(); chk("t1_done", {24'd0, ctl}, {24'd0, 4'h0, 4'b0011});
    tick(); chk("t1_idle", {24'd0, ctl}, 32'h00);
    chk("t1_cnt_hold", frame_cnt, 32'd5);
    chk("t1_tflag", {31'd0, tmo_flag}, 32'd0);

    // 2: idle timeout 8 cycles after the last frame
    mask = 4'b0011; fmax = 0; tmo = 8; tx_done = 1; start = 1;
    tick(); chk("t2_cnt_clr", frame_cnt, 32'd0);
    start = 0;
    tick();
    hsked = 1; repeat (2) tick();
    hsked = 0;
    repeat (7) tick();
    chk("t2_recv7", {24'd0, ctl}, {24'd0, 4'b0011, 4'b1001});
    tick(); chk("t2_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    chk("t2_tflag", {31'd0, tmo_flag}, 32'd1);
    chk("t2_cnt", frame_cnt, 32'd2);
    tick(); tick(); chk("t2_done", {24'd0, ctl}, {24'd0, 4'h0, 4'b0011});
    tick(); chk("t2_tflag_sticky", {31'd0, tmo_flag}, 32'd1);

    // 3: last frame coincides with the timeout cycle; count wins
    mask = 4'hF; fmax = 3; tmo = 4; start = 1;
    tick(); chk("t3_tflag_clr", {31'd0, tmo_flag}, 32'd0);
    start = 0;
    tick();
    hsked = 1; repeat (2) tick();
    hsked = 0; repeat (3) tick();
    chk("t3_recv", {24'd0, ctl}, {24'd0, 4'hF, 4'b1001});
    hsked = 1;
    tick(); chk("t3_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    chk("t3_tflag", {31'd0, tmo_flag}, 32'd0);
    chk("t3_cnt", frame_cnt, 32'd3);
    hsked = 0;
    tick(); tick(); tick();
    chk("t3_idle", {24'd0, ctl}, 32'h00);

    // 4: abort, then long drain gated by fifo_empty and recv_busy
    mask = 4'b0101; fmax = 0; tmo = 0; fifo_empty = 0; start = 1;
    tick(); start = 0;
    tick();
    hsked = 1; repeat (3) tick();
    hsked = 0; repeat (6) tick();
    chk("t4_recv", {24'd0, ctl}, {24'd0, 4'b0101, 4'b1001});
    abort = 1;
    tick(); chk("t4_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    recv_busy = 1;
    tick();
    hsked = 1; tick(); hsked = 0;
    repeat (17) tick();
    chk("t4_drain", {24'd0, ctl}, {24'd0, 4'h0, 4'b1001});
    fifo_empty = 1;
    tick(); chk("t4_busy_hold", {24'd0, ctl}, {24'd0, 4'h0, 4'b1001});
    recv_busy = 0;
    tick(); chk("t4_done", {24'd0, ctl}, {24'd0, 4'h0, 4'b0011});
    chk("t4_cnt", frame_cnt, 32'd4);
    abort = 0;
    tick();
    start = 1; abort = 1;
    tick(); chk("t4_start_abort", {24'd0, ctl}, 32'h00);
    chk("t4_cnt_kept", frame_cnt, 32'd4);
    start = 0; abort = 0;

    // 5: asynchronous reset while draining, then a fresh run
    mask = 4'hF; fmax = 0; tmo = 0; fifo_empty = 0; start = 1;
    tick(); start = 0;
    tick();
    hsked = 1; tick(); hsked = 0;
    abort = 1; tick(); abort = 0;
    tick(); chk("t5_drain", {24'd0, ctl}, {24'd0, 4'h0, 4'b1001});
    #2 rst_n = 1'b0;
    #1 chk("t5_async_ctl", {24'd0, ctl}, 32'h00);
    chk("t5_async_cnt", frame_cnt, 32'd0);
    #2 rst_n = 1'b1;
    mask = 4'b1000; fmax = 2; fifo_empty = 1; start = 1;
    tick(); chk("t5_rearm", {24'd0, ctl}, {24'd0, 4'b1000, 4'b1001});
    start = 0;
    tick();
    hsked = 1; repeat (2) tick(); hsked = 0;
    chk("t5_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    tick(); tick(); chk("t5_done", {24'd0, ctl}, {24'd0, 4'h0, 4'b0011});
    tick();

    // 6: start pulses in RECV and DONE are ignored
    mask = 4'b0110; fmax = 3; tmo = 0; start = 1;
    tick(); start = 0;
    tick();
    mask = 4'hF; fmax = 1; start = 1;
    tick(); start = 0;
    chk("t6_mask_kept", {24'd0, ctl}, {24'd0, 4'b0110, 4'b1001});
    hsked = 1; tick(); hsked = 0;
    chk("t6_max_kept", {24'd0, ctl}, {24'd0, 4'b0110, 4'b1001});
    hsked = 1; repeat (2) tick(); hsked = 0;
    chk("t6_flush", {24'd0, ctl}, {24'd0, 4'h0, 4'b1101});
    tick(); tick(); chk("t6_done", {24'd0, ctl}, {24'd0, 4'h0, 4'b0011});
    start = 1;
    tick(); start = 0;
    chk("t6_idle", {24'd0, ctl}, 32'h00);
    tick(); chk("t6_still_idle", {24'd0, ctl}, 32'h00);
    chk("t6_cnt", frame_cnt, 32'd3);
    chk("rx_done_pulses", rxd_pulses, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
